// File: rtl/ovl_win_rd_responder.sv
// ovl_win_rd_responder
//   Read responder for the rd/rd_ack windowed-read protocol. A level-held rd
//   request is answered with rd_ack after a programmable latency. data_out is
//   frozen from the cycle rd is first sampled high until rd_ack deasserts, so
//   the block can feed a win_unchange checker directly
//   (start_event=rd, test_expr=data_out, end_event=rd_ack).
//
//   Optional feature macro: OVL_RESP_STATS_EN
//     defined     -> ack_count is a saturating 8-bit completion counter
//     not defined -> ack_count is tied to 0, no counter register exists
//
// Ports
//   clock      in   sole clock, rising edge
//   reset      in   synchronous, active-high reset
//   enable     in   low: FSM, latency counter and buffer hold their values
//   rd         in   read request, held until rd_ack is seen
//   rd_ack     out  registered acknowledge, held until rd drops
//   data_out   out  registered read data (one-entry prefetch buffer)
//   lat        in   acknowledge latency, sampled when a request is accepted
//   src_data   in   prefetch data from upstream
//   src_valid  in   src_data valid
//   src_ready  out  combinational: src_data is loaded this cycle if valid
//   underrun   out  one-cycle pulse: request accepted with no fresh data
//   ack_count  out  completed-transaction count
module ovl_win_rd_responder #(
  parameter int WIDTH = 8,
  parameter int LAT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             rd,
  output logic             rd_ack,
  output logic [WIDTH-1:0] data_out,
  input  logic [LAT_W-1:0] lat,
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             underrun,
  output logic [7:0]       ack_count
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               dv_q, dv_d;
  logic               rd_ack_q, rd_ack_d;
  logic               underrun_q, underrun_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               load;

  // Loading is only possible in IDLE with no request pending, which is what
  // keeps data_out frozen across the whole rd..rd_ack window.
  assign src_ready = enable & ~reset & (state_q == IDLE) & ~rd & ~dv_q;
  assign load      = src_valid & src_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dv_d       = dv_q;
    rd_ack_d   = rd_ack_q;
    underrun_d = 1'b0;
    data_d     = data_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (rd) begin
            state_d    = WAIT;
            cnt_d      = lat;
            underrun_d = ~dv_q;
          end else if (load) begin
            data_d = src_data;
            dv_d   = 1'b1;
          end
        end
        WAIT: begin
          // Abort leaves data_valid set: the buffered word is not consumed.
          if (!rd) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            state_d  = ACK;
            rd_ack_d = 1'b1;
          end else begin
            cnt_d = cnt_q - LAT_W'(1);
          end
        end
        ACK: begin
          if (!rd) begin
            state_d  = IDLE;
            rd_ack_d = 1'b0;
            dv_d     = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dv_q       <= 1'b0;
      rd_ack_q   <= 1'b0;
      underrun_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dv_q       <= dv_d;
      rd_ack_q   <= rd_ack_d;
      underrun_q <= underrun_d;
      data_q     <= data_d;
    end
  end

  assign rd_ack   = rd_ack_q;
  assign underrun = underrun_q;
  assign data_out = data_q;

`ifdef OVL_RESP_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] ack_cnt_q;
  logic       ack_done;

  // Completion is the ACK->IDLE transition.
  assign ack_done = enable & (state_q == ACK) & ~rd;

  always_ff @(posedge clock) begin
    if (reset)         ack_cnt_q <= 8'd0;
    else if (ack_done) ack_cnt_q <= sat_inc8(ack_cnt_q);
  end

  assign ack_count = ack_cnt_q;
`else
  assign ack_count = 8'd0;
`endif

endmodule

// File: tb/tb_ovl_win_rd_responder.sv
// Testbench for ovl_win_rd_responder: random transactions with a
// transaction-level reference model and a queue-based scoreboard.
module tb_ovl_win_rd_responder;

  logic       clk = 1'b0;
  logic       reset, enable, rd, src_valid;
  logic [3:0] lat;
  logic [7:0] src_data;
  logic       rd_ack, src_ready, underrun;
  logic [7:0] data_out, ack_count;

  always #5 clk = ~clk;

  ovl_win_rd_responder #(.WIDTH(8), .LAT_W(4)) dut (
    .clock(clk), .reset(reset), .enable(enable), .rd(rd), .rd_ack(rd_ack),
    .data_out(data_out), .lat(lat), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .underrun(underrun), .ack_count(ack_count)
  );

  typedef struct {
    logic [7:0] data;
    int         k;    // edges from acceptance to rd_ack rise
    int         ur;   // underrun pulses expected in the window
  } exp_t;

  exp_t exp_q[$];
  int   cnt_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  logic [7:0] m_data;
  bit         m_dv;
  int         m_count;
  int         completed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int next_count(input int c);
`ifdef OVL_RESP_STATS_EN
    return (c >= 255) ? 255 : c + 1;
`else
    return 0 * c;
`endif
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit         prev_rd, prev_ack, active;
    logic [7:0] prev_data;
    int         t, ur_cnt;
    exp_t       e;
    int         c;
    prev_rd = 0; prev_ack = 0; active = 0; prev_data = 0; t = 0; ur_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_rd = 0; prev_ack = 0; active = 0; prev_data = data_out;
        continue;
      end
      if (active) t++;
      if (underrun === 1'b1) ur_cnt++;
      if (prev_rd || prev_ack) chk("data_hold", 32'(data_out), 32'(prev_data));
      if (rd) chk("src_ready_during_rd", 32'(src_ready), 32'd0);
      if (rd_ack && !prev_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_latency", 32'(t - 1), 32'(e.k));
          chk("ack_data", 32'(data_out), 32'(e.data));
          chk("underrun_pulses", 32'(ur_cnt), 32'(e.ur));
        end
        active = 0;
      end
      if (!rd_ack && prev_ack) begin
        if (cnt_q.size() == 0) begin
          chk("unexpected_ack_fall", 32'd1, 32'd0);
        end else begin
          c = cnt_q.pop_front();
          chk("ack_count", 32'(ack_count), 32'(c));
        end
      end
      if (rd && !prev_rd) begin
        active = 1; t = 0; ur_cnt = 0;
      end
      prev_rd = rd; prev_ack = rd_ack; prev_data = data_out;
    end
  end

  // ---------------- one transaction ----------------
  // fl/fg: forced latency / enable-gap (-1 random); fa: abort (-1 random, 0, 1)
  // fd: prefetch (-1 random, -2 none, >=0 load that value if buffer empty)
  task automatic do_txn(input int fl, input int fg, input int fa, input int fd);
    int         L, g, a, h;
    bit         abort_t, got;
    exp_t       e;
    logic [7:0] d;
    if (!m_dv && (fd >= 0 || (fd == -1 && $urandom_range(0, 3) != 0))) begin
      d = (fd >= 0) ? 8'(fd) : 8'($urandom);
      src_data = d; src_valid = 1; #1;
      chk("src_ready_empty", 32'(src_ready), 32'd1);
      step;
      src_valid = 0; m_data = d; m_dv = 1;
      chk("src_ready_after_load", 32'(src_ready), 32'd0);
    end else if (m_dv && fd == -1 && $urandom_range(0, 2) == 0) begin
      src_data = 8'($urandom); src_valid = 1; #1;
      chk("src_ready_full", 32'(src_ready), 32'd0);
      step;
      src_valid = 0;
    end
    L = (fl >= 0) ? fl : $urandom_range(0, 15);
    g = (fg >= 0) ? fg : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    if (fa >= 0) abort_t = (fa == 1);
    else         abort_t = (L >= 2) && ($urandom_range(0, 7) == 0);
    if (abort_t) g = 0;
    lat = 4'(L); rd = 1;
    src_valid = 1'($urandom_range(0, 1)); src_data = 8'($urandom);
    if (!abort_t) begin
      e.data = m_data; e.k = L + 1 + g; e.ur = m_dv ? 0 : 1;
      exp_q.push_back(e);
    end
    step;                       // acceptance edge
    lat = 4'($urandom);         // must not affect this transaction
    if (g > 0) begin
      enable = 0;
      repeat (g) step;
      enable = 1;
    end
    if (abort_t) begin
      a = (fa == 1) ? 2 : $urandom_range(0, L - 1);
      repeat (a) step;
      rd = 0; src_valid = 0;
      step;
      chk("abort_no_ack", 32'(rd_ack), 32'd0);
      return;
    end
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd_ack) begin got = 1; break; end
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      rd = 0; src_valid = 0; reset = 1;
      step;
      reset = 0;
      exp_q.delete(); cnt_q.delete();
      m_dv = 0; m_data = 0; m_count = 0;
      return;
    end
    step;
    h = $urandom_range(0, 2);
    repeat (h) step;
    rd = 0; src_valid = 0;
    m_count = next_count(m_count);
    cnt_q.push_back(m_count);
    step;
    chk("ack_fall", 32'(rd_ack), 32'd0);
    m_dv = 0;
    completed++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    exp_t e;
    reset = 1; enable = 1; rd = 0; src_valid = 0; lat = 0; src_data = 0;
    repeat (3) step;
    chk("rst_rd_ack", 32'(rd_ack), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_ack_count", 32'(ack_count), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    reset = 0;
    m_data = 0; m_dv = 0; m_count = 0; completed = 0;
    step;

    do_txn(3, 0, 0, 'hA5);   // prefetch A5, lat 3
    do_txn(0, 0, 0, -2);     // empty buffer: underrun, old data held
    do_txn(5, 0, 1, 'h77);   // abort after 2 of 5 cycles
    do_txn(5, 0, 0, -2);     // retried request returns the same data
    do_txn(2, 3, 0, -1);     // enable low 3 cycles inside WAIT

    while (completed < 300) do_txn(-1, -1, -1, -1);

    repeat (2) step;
    chk("final_ack_count", 32'(ack_count), 32'(m_count));
`ifdef OVL_RESP_STATS_EN
    chk("ack_count_saturated", 32'(ack_count), 32'd255);
`endif

    // reset while in ACK
    src_data = 8'h5A; src_valid = 1; #1;
    chk("src_ready_pre_reset", 32'(src_ready), 32'd1);
    step;
    src_valid = 0; lat = 4'd1; rd = 1;
    e.data = 8'h5A; e.k = 2; e.ur = 0;
    exp_q.push_back(e);
    step;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_ack) begin got = 1; break; end
    end
    chk("reset_test_ack_seen", 32'(got), 32'd1);
    step;
    reset = 1;
    step;
    chk("mid_reset_rd_ack", 32'(rd_ack), 32'd0);
    chk("mid_reset_data_out", 32'(data_out), 32'd0);
    chk("mid_reset_ack_count", 32'(ack_count), 32'd0);
    chk("mid_reset_src_ready", 32'(src_ready), 32'd0);
    reset = 0; rd = 0;
    #1;
    chk("post_reset_buffer_empty", 32'(src_ready), 32'd1);
    step;
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("cnt_queue_drained", 32'(cnt_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ovl_win_rd_responder.md
# ovl_win_rd_responder

Read responder for the rd/rd_ack windowed-read protocol that `ovl_win_unchange` monitors. It answers a level-held `rd` request with `rd_ack` after a programmable latency. `data_out` is guaranteed unchanged from the cycle `rd` is first sampled high until `rd_ack` deasserts. The block is the DUT-side counterpart for the OVL window tests and connects directly to a checker instance: `start_event=rd`, `test_expr=data_out`, `end_event=rd_ack`.

## Interface
- `WIDTH`, 8 — data width.
- `LAT_W`, 4 — width of the latency input.

- `clock`  in  1  — sole clock; all logic on the rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `enable`  in  1  — when low, the FSM, counter and buffer hold their values.
- `rd`  in  1  — read request; level, held by the initiator until `rd_ack` is seen.
- `rd_ack`  out  1  — registered acknowledge; held high until `rd` drops.
- `data_out`  out  WIDTH  — registered read data.
- `lat`  in  LAT_W  — acknowledge latency in cycles; sampled when a request is accepted.
- `src_data`  in  WIDTH  — prefetch data from upstream.
- `src_valid`  in  1  — `src_data` valid.
- `src_ready`  out  1  — combinational; responder will load `src_data` this cycle.
- `underrun`  out  1  — one-cycle pulse: a request was accepted with no fresh data.
- `ack_count`  out  8  — completed-transaction count (see Configuration).

## Operation
- One-entry prefetch register `data_out` with a `data_valid` flag.
- `src_ready = enable & (state==IDLE) & ~rd & ~data_valid`.
- A load happens when `src_valid & src_ready`: `data_out <= src_data`, `data_valid <= 1`.
- `data_out` never changes while `rd` is high, while `rd_ack` is high, or in states WAIT or ACK.
- FSM states: IDLE, WAIT, ACK. All transitions below require `enable=1`.
  - IDLE, `rd=1`: go to WAIT, `cnt <= lat`. If `data_valid=0`, pulse `underrun`; `data_out` keeps its old value.
  - WAIT, `rd=0`: abort. Go to IDLE; no ack; `data_valid` unchanged, so the data is not consumed.
  - WAIT, `rd=1`, `cnt==0`: go to ACK, `rd_ack <= 1`.
  - WAIT, `rd=1`, `cnt!=0`: `cnt <= cnt-1`.
  - ACK, `rd=1`: hold `rd_ack=1`.
  - ACK, `rd=0`: `rd_ack <= 0`, `data_valid <= 0`, increment `ack_count`, go to IDLE.
- A load is never accepted while `rd=1`, so a load and a request never coincide.

## Timing
- Reset values: state IDLE, `rd_ack=0`, `data_out=0`, `data_valid=0`, `cnt=0`, `underrun=0`, `ack_count=0`.
- `src_ready` is 0 during reset.
- Latency: if `rd` is first sampled high at edge E0, `rd_ack` is high after edge E0+lat+1.
  - `lat=0` gives `rd_ack` one cycle after acceptance.
  - `lat=15` (max with `LAT_W=4`) gives `rd_ack` 16 cycles after acceptance.
- `rd_ack` falls one edge after `rd` is sampled low in ACK.
- The earliest next acceptance is the edge after the return to IDLE.
- `lat` changing after acceptance has no effect on the current transaction.
- `enable` low mid-WAIT freezes `cnt`; the latency extends by the frozen cycles.
- `enable` low in ACK holds `rd_ack` high even if `rd` drops.
- Reset mid-transaction: all registers return to reset values on the next edge.
  - `rd_ack` drops with no completion count.
  - Buffered data is discarded.

## Configuration
- `OVL_RESP_STATS_EN` defined: `ack_count` is an 8-bit counter.
  - Increments on each ACK→IDLE transition.
  - Saturates at 255.
  - Cleared by reset.
- Not defined: `ack_count` is tied to 0 and no counter register is built. All other behaviour is identical.

## Test plan
- Prefetch 8'hA5 then `rd=1` with `lat=3`:
  - `src_ready` drops after the load.
  - `rd_ack` rises 4 cycles after acceptance.
  - `data_out=8'hA5` constant throughout.
  - After `rd=0`, `rd_ack=0` one cycle later and `ack_count=1`.
- Drive `src_valid=1`, `src_data=8'h3C` continuously while `rd=1` and `rd_ack=1`:
  - `data_out` never changes inside the window.
  - The OVL `win_unchange` checker reports no fire.
- `rd=1` with an empty buffer and `lat=0`:
  - `underrun` pulses once.
  - `rd_ack` rises one cycle after acceptance.
  - `data_out` holds the previous value.
- Drop `rd` during WAIT after 2 of `lat=5` cycles:
  - No `rd_ack`; state returns to IDLE.
  - `data_valid` stays 1.
  - The next request is acked with the same data.
- Drive `enable=0` for 3 cycles inside WAIT with `lat=2`: `rd_ack` rises at acceptance+6.
- Assert `reset` while in ACK: `rd_ack=0`, `data_out=0`, `ack_count=0` on the next edge.
- Compile with and without `OVL_RESP_STATS_EN` and run 300 transactions:
  - With the macro, `ack_count` saturates at 255.
  - Without it, `ack_count` is constant 0.
